// File: rtl/obi_err_tracker.sv
// Multi-channel OBI error tracker. Passively follows each OBI channel, matches
// responses to their in-order requests and collects errored responses into a
// shared log with a pop handshake, sticky status flags and an interrupt.
module obi_err_tracker #(
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned MetaWidth       = 1,
  parameter int unsigned ErrBits         = 1,
  parameter int unsigned NumOutstanding  = 2,
  parameter int unsigned NumStoredErrors = 4,
  parameter bit          DropOldest      = 1'b0,
  parameter int unsigned CntWidth        = 16,
  localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumChannels-1:0]                obi_req_i,
  input  logic [NumChannels-1:0]                obi_gnt_i,
  input  logic [NumChannels-1:0][AddrWidth-1:0] obi_addr_i,
  input  logic [NumChannels-1:0][MetaWidth-1:0] obi_meta_i,
  input  logic [NumChannels-1:0]                obi_rvalid_i,
  input  logic [NumChannels-1:0][ErrBits-1:0]   obi_err_i,
  output logic                                  err_valid_o,
  input  logic                                  err_ready_i,
  output logic [ChW-1:0]                        err_chan_o,
  output logic [AddrWidth-1:0]                  err_addr_o,
  output logic [MetaWidth-1:0]                  err_meta_o,
  output logic [ErrBits-1:0]                    err_code_o,
  output logic                                  err_irq_o,
  output logic                                  overflow_o,
  output logic                                  proto_err_o,
  output logic [CntWidth-1:0]                   err_count_o,
  input  logic                                  clear_i
);

  localparam int unsigned TPtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned TCntW = $clog2(NumOutstanding + 1);
  localparam int unsigned LPtrW = (NumStoredErrors > 1) ? $clog2(NumStoredErrors) : 1;
  localparam int unsigned LCntW = $clog2(NumStoredErrors + 1);

  logic [NumChannels-1:0] slot_vld, slot_ovf, arb_gnt, trk_proto, err_ev;
  logic [AddrWidth-1:0]   slot_addr [NumChannels];
  logic [MetaWidth-1:0]   slot_meta [NumChannels];
  logic [ErrBits-1:0]     slot_code [NumChannels];

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    logic [AddrWidth-1:0] mem_addr_q [NumOutstanding];
    logic [MetaWidth-1:0] mem_meta_q [NumOutstanding];
    logic [TPtrW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [TCntW-1:0]     cnt_q, cnt_d;
    logic                 full, empty, req_acc, push, pop;
    logic                 sv_q, sv_d, ovf;
    logic [AddrWidth-1:0] sa_q, sa_d;
    logic [MetaWidth-1:0] sm_q, sm_d;
    logic [ErrBits-1:0]   se_q, se_d;

    assign full    = (cnt_q == TCntW'(NumOutstanding));
    assign empty   = (cnt_q == '0);
    assign req_acc = obi_req_i[c] & obi_gnt_i[c];
    // A response never belongs to a same-cycle grant, so empty means unexpected.
    assign pop     = obi_rvalid_i[c] & ~empty;
    assign push    = req_acc & (~full | pop);
    assign trk_proto[c] = (req_acc & full & ~pop) | (obi_rvalid_i[c] & empty);
    assign err_ev[c]    = pop & (|obi_err_i[c]);

    // Tracker pointer and occupancy update.
    always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (pop)  rd_d = (rd_q == TPtrW'(NumOutstanding - 1)) ? '0 : rd_q + TPtrW'(1);
      if (push) wr_d = (wr_q == TPtrW'(NumOutstanding - 1)) ? '0 : wr_q + TPtrW'(1);
      if (push && !pop)      cnt_d = cnt_q + TCntW'(1);
      else if (pop && !push) cnt_d = cnt_q - TCntW'(1);
    end

    // Tracker control state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
      end
    end

    // Tracker storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
      if (push) begin
        mem_addr_q[wr_q] <= obi_addr_i[c];
        mem_meta_q[wr_q] <= obi_meta_i[c];
      end
    end

    // Pending slot: a grant frees it in time to capture an error at the same edge.
    always_comb begin
      sv_d = sv_q & ~arb_gnt[c];
      sa_d = sa_q;
      sm_d = sm_q;
      se_d = se_q;
      ovf  = 1'b0;
      if (err_ev[c]) begin
        if (sv_d) begin
          ovf = 1'b1;
        end else begin
          sv_d = 1'b1;
          sa_d = mem_addr_q[rd_q];
          sm_d = mem_meta_q[rd_q];
          se_d = obi_err_i[c];
        end
      end
    end

    // Pending slot state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sv_q <= 1'b0;
        sa_q <= '0;
        sm_q <= '0;
        se_q <= '0;
      end else begin
        sv_q <= sv_d;
        sa_q <= sa_d;
        sm_q <= sm_d;
        se_q <= se_d;
      end
    end

    assign slot_vld[c]  = sv_q;
    assign slot_ovf[c]  = ovf;
    assign slot_addr[c] = sa_q;
    assign slot_meta[c] = sm_q;
    assign slot_code[c] = se_q;
  end

  // Error log.
  logic [ChW-1:0]       log_chan_q [NumStoredErrors];
  logic [AddrWidth-1:0] log_addr_q [NumStoredErrors];
  logic [MetaWidth-1:0] log_meta_q [NumStoredErrors];
  logic [ErrBits-1:0]   log_code_q [NumStoredErrors];
  logic [LPtrW-1:0]     lrd_q, lrd_d, lwr_q, lwr_d;
  logic [LCntW-1:0]     lcnt_q, lcnt_d;
  logic                 log_valid, log_full, log_pop, log_push, log_drop, log_adv, log_accept;
  logic [ChW-1:0]       rr_q, rr_d, gnt_idx;
  logic                 ovf_q, ovf_d, proto_q, proto_d, irq_q;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [CntWidth:0]    n_err, sum;

  assign log_valid  = (lcnt_q != '0);
  assign log_full   = (lcnt_q == LCntW'(NumStoredErrors));
  assign log_pop    = log_valid & err_ready_i;
  assign log_accept = ~log_full | log_pop | DropOldest;
  assign log_drop   = log_push & log_full & ~log_pop;
  assign log_adv    = log_pop | log_drop;

  // Round-robin pick among occupied slots, starting at the priority pointer.
  always_comb begin
    int unsigned idx;
    arb_gnt  = '0;
    gnt_idx  = '0;
    log_push = 1'b0;
    idx      = 0;
    if (log_accept) begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        idx = (int'(rr_q) + i) % NumChannels;
        if (!log_push && slot_vld[idx]) begin
          log_push     = 1'b1;
          gnt_idx      = ChW'(idx);
          arb_gnt[idx] = 1'b1;
        end
      end
    end
    rr_d = rr_q;
    if (log_push) rr_d = (gnt_idx == ChW'(NumChannels - 1)) ? '0 : gnt_idx + ChW'(1);
  end

  // Log pointers, error counter and sticky flags.
  always_comb begin
    lrd_d  = lrd_q;
    lwr_d  = lwr_q;
    lcnt_d = lcnt_q;
    if (log_adv)  lrd_d = (lrd_q == LPtrW'(NumStoredErrors - 1)) ? '0 : lrd_q + LPtrW'(1);
    if (log_push) lwr_d = (lwr_q == LPtrW'(NumStoredErrors - 1)) ? '0 : lwr_q + LPtrW'(1);
    if (log_push && !log_adv)      lcnt_d = lcnt_q + LCntW'(1);
    else if (log_adv && !log_push) lcnt_d = lcnt_q - LCntW'(1);

    n_err = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      n_err = n_err + {{CntWidth{1'b0}}, err_ev[c]};
    end
    sum   = (clear_i ? '0 : {1'b0, cnt_q}) + n_err;
    cnt_d = sum[CntWidth] ? '1 : sum[CntWidth-1:0];

    ovf_d   = clear_i ? 1'b0 : (ovf_q | (|slot_ovf) | log_drop);
    proto_d = clear_i ? 1'b0 : (proto_q | (|trk_proto));
  end

  // Log control, arbiter pointer and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lrd_q   <= '0;
      lwr_q   <= '0;
      lcnt_q  <= '0;
      rr_q    <= '0;
      ovf_q   <= 1'b0;
      proto_q <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      lrd_q   <= lrd_d;
      lwr_q   <= lwr_d;
      lcnt_q  <= lcnt_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      proto_q <= proto_d;
      cnt_q   <= cnt_d;
      irq_q   <= log_valid | ovf_q;
    end
  end

  // Log storage; head outputs are gated so stale contents never show.
  always_ff @(posedge clk_i) begin
    if (log_push) begin
      log_chan_q[lwr_q] <= gnt_idx;
      log_addr_q[lwr_q] <= slot_addr[gnt_idx];
      log_meta_q[lwr_q] <= slot_meta[gnt_idx];
      log_code_q[lwr_q] <= slot_code[gnt_idx];
    end
  end

  assign err_valid_o = log_valid;
  assign err_chan_o  = log_valid ? log_chan_q[lrd_q] : '0;
  assign err_addr_o  = log_valid ? log_addr_q[lrd_q] : '0;
  assign err_meta_o  = log_valid ? log_meta_q[lrd_q] : '0;
  assign err_code_o  = log_valid ? log_code_q[lrd_q] : '0;
  assign err_irq_o   = irq_q;
  assign overflow_o  = ovf_q;
  assign proto_err_o = proto_q;
  assign err_count_o = cnt_q;

endmodule

// File: tb/tb_obi_err_tracker.sv
// Directed bench for obi_err_tracker: a default instance plus two small-log
// instances (stalling and drop-oldest) sharing the same stimulus.
module tb_obi_err_tracker;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       req, gnt, rvalid;
  logic [1:0][31:0] addr;
  logic [1:0][0:0]  meta, err;
  logic             err_ready, clear;

  logic        a_valid, a_irq, a_ovf, a_proto;
  logic [0:0]  a_chan, a_meta, a_code;
  logic [31:0] a_addr;
  logic [15:0] a_count;
  logic        b_valid, b_irq, b_ovf, b_proto;
  logic [0:0]  b_chan, b_meta, b_code;
  logic [31:0] b_addr;
  logic [15:0] b_count;
  logic        c_valid, c_irq, c_ovf, c_proto;
  logic [0:0]  c_chan, c_meta, c_code;
  logic [31:0] c_addr;
  logic [15:0] c_count;

  int total = 0;
  int bad   = 0;

  obi_err_tracker dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .obi_req_i(req), .obi_gnt_i(gnt), .obi_addr_i(addr),
    .obi_meta_i(meta), .obi_rvalid_i(rvalid), .obi_err_i(err), .err_valid_o(a_valid),
    .err_ready_i(err_ready), .err_chan_o(a_chan), .err_addr_o(a_addr), .err_meta_o(a_meta),
    .err_code_o(a_code), .err_irq_o(a_irq), .overflow_o(a_ovf), .proto_err_o(a_proto),
    .err_count_o(a_count), .clear_i(clear)
  );

  obi_err_tracker #(.NumStoredErrors(2), .DropOldest(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .obi_req_i(req), .obi_gnt_i(gnt), .obi_addr_i(addr),
    .obi_meta_i(meta), .obi_rvalid_i(rvalid), .obi_err_i(err), .err_valid_o(b_valid),
    .err_ready_i(err_ready), .err_chan_o(b_chan), .err_addr_o(b_addr), .err_meta_o(b_meta),
    .err_code_o(b_code), .err_irq_o(b_irq), .overflow_o(b_ovf), .proto_err_o(b_proto),
    .err_count_o(b_count), .clear_i(clear)
  );

  obi_err_tracker #(.NumStoredErrors(2), .DropOldest(1'b1)) dut_c (
    .clk_i(clk), .rst_ni(rst_ni), .obi_req_i(req), .obi_gnt_i(gnt), .obi_addr_i(addr),
    .obi_meta_i(meta), .obi_rvalid_i(rvalid), .obi_err_i(err), .err_valid_o(c_valid),
    .err_ready_i(err_ready), .err_chan_o(c_chan), .err_addr_o(c_addr), .err_meta_o(c_meta),
    .err_code_o(c_code), .err_irq_o(c_irq), .overflow_o(c_ovf), .proto_err_o(c_proto),
    .err_count_o(c_count), .clear_i(clear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; gnt = '0; rvalid = '0; err = '0; err_ready = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic grant(input int ch, input logic [31:0] a, input logic m);
    req[ch] = 1'b1; gnt[ch] = 1'b1; addr[ch] = a; meta[ch] = m;
    tick();
    idle();
  endtask

  task automatic respond(input logic [1:0] rv, input logic [1:0] e);
    rvalid = rv;
    err[0] = e[0];
    err[1] = e[1];
    tick();
    idle();
  endtask

  initial begin
    idle();
    addr = '0;
    meta = '0;
    rst_ni = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_chan",  32'(a_chan),  0);
    chk("rst_addr",  a_addr,       0);
    chk("rst_irq",   32'(a_irq),   0);
    chk("rst_ovf",   32'(a_ovf),   0);
    chk("rst_proto", 32'(a_proto), 0);
    chk("rst_count", 32'(a_count), 0);
    rst_ni = 1'b1;

    // Single error: grant, response two cycles later, log/irq latency.
    grant(0, 32'h1000, 1'b1);
    tick();
    respond(2'b01, 2'b01);
    chk("t1_valid_early", 32'(a_valid), 0);
    chk("t1_count", 32'(a_count), 1);
    tick();
    chk("t1_valid", 32'(a_valid), 1);
    chk("t1_chan",  32'(a_chan),  0);
    chk("t1_addr",  a_addr,       32'h1000);
    chk("t1_meta",  32'(a_meta),  1);
    chk("t1_code",  32'(a_code),  1);
    chk("t1_irq_early", 32'(a_irq), 0);
    tick();
    chk("t1_irq", 32'(a_irq), 1);
    err_ready = 1'b1;
    tick();
    idle();
    chk("t1_pop_valid", 32'(a_valid), 0);
    chk("t1_pop_addr",  a_addr,       0);
    tick();
    chk("t1_irq_clear", 32'(a_irq), 0);

    // In-order matching: ok response pops 0xA0, errored one belongs to 0xB0.
    grant(0, 32'hA0, 1'b0);
    grant(0, 32'hB0, 1'b0);
    respond(2'b01, 2'b00);
    respond(2'b01, 2'b01);
    tick();
    chk("t2_addr",  a_addr,        32'hB0);
    chk("t2_count", 32'(a_count),  2);
    err_ready = 1'b1;
    tick();
    idle();

    // Round robin across channels.
    do_reset();
    req = 2'b11; gnt = 2'b11; addr[0] = 32'h10; addr[1] = 32'h20;
    tick();
    idle();
    respond(2'b11, 2'b11);
    tick();
    chk("t3_first_chan", 32'(a_chan), 0);
    chk("t3_first_addr", a_addr,      32'h10);
    err_ready = 1'b1;
    tick();
    idle();
    chk("t3_second_chan", 32'(a_chan), 1);
    chk("t3_second_addr", a_addr,      32'h20);
    err_ready = 1'b1;
    tick();
    idle();
    chk("t3_drained", 32'(a_valid), 0);
    grant(0, 32'h30, 1'b0);
    respond(2'b01, 2'b01);
    tick();
    chk("t3_single_addr", a_addr, 32'h30);
    err_ready = 1'b1;
    tick();
    idle();
    req = 2'b11; gnt = 2'b11; addr[0] = 32'h40; addr[1] = 32'h50;
    tick();
    idle();
    respond(2'b11, 2'b11);
    tick();
    chk("t3_rr_chan", 32'(a_chan), 1);
    chk("t3_rr_addr", a_addr,      32'h50);
    err_ready = 1'b1;
    tick();
    idle();
    chk("t3_rr_next_chan", 32'(a_chan), 0);
    chk("t3_rr_next_addr", a_addr,      32'h40);
    err_ready = 1'b1;
    tick();
    idle();
    chk("t3_count", 32'(a_count), 5);

    // Log overflow with a 2-entry log: stalling versus drop-oldest.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      grant(0, 32'(k * 256), 1'b0);
      respond(2'b01, 2'b01);
    end
    grant(0, 32'h400, 1'b0);
    chk("t4_stall_ovf_early", 32'(b_ovf), 0);
    chk("t4_stall_head",      b_addr,     32'h100);
    chk("t4_drop_ovf",        32'(c_ovf), 1);
    chk("t4_drop_head",       c_addr,     32'h200);
    respond(2'b01, 2'b01);
    chk("t4_stall_ovf",   32'(b_ovf),   1);
    chk("t4_stall_head2", b_addr,       32'h100);
    chk("t4_stall_count", 32'(b_count), 4);
    tick();
    chk("t4_drop_head2", c_addr,       32'h300);
    chk("t4_big_ovf",    32'(a_ovf),   0);
    chk("t4_big_count",  32'(a_count), 4);
    clear = 1'b1;
    tick();
    idle();
    chk("t4_clear_ovf",   32'(b_ovf),   0);
    chk("t4_clear_count", 32'(b_count), 0);

    // Protocol errors and clear behaviour.
    do_reset();
    grant(1, 32'h700, 1'b0);
    grant(1, 32'h704, 1'b0);
    chk("t5_proto_none", 32'(a_proto), 0);
    grant(1, 32'h708, 1'b0);
    chk("t5_overrun", 32'(a_proto), 1);
    clear = 1'b1;
    tick();
    idle();
    chk("t5_clear_proto", 32'(a_proto), 0);
    respond(2'b01, 2'b01);
    chk("t5_unexp_proto", 32'(a_proto), 1);
    chk("t5_unexp_count", 32'(a_count), 0);
    tick();
    chk("t5_unexp_nolog", 32'(a_valid), 0);
    respond(2'b10, 2'b10);
    chk("t5_ch1_count", 32'(a_count), 1);
    tick();
    chk("t5_ch1_addr", a_addr,      32'h700);
    chk("t5_ch1_chan", 32'(a_chan), 1);
    clear = 1'b1;
    respond(2'b11, 2'b11);
    chk("t5_clear_wins", 32'(a_proto), 0);
    chk("t5_clear_inc",  32'(a_count), 1);
    chk("t5_clear_ovf",  32'(a_ovf),   0);

    // Reset in the middle of traffic.
    do_reset();
    grant(0, 32'h111, 1'b0);
    respond(2'b01, 2'b01);
    grant(0, 32'h222, 1'b0);
    grant(0, 32'h333, 1'b0);
    chk("t6_pre_valid", 32'(a_valid), 1);
    chk("t6_pre_irq",   32'(a_irq),   1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(a_valid), 0);
    chk("t6_rst_addr",  a_addr,       0);
    chk("t6_rst_irq",   32'(a_irq),   0);
    chk("t6_rst_count", 32'(a_count), 0);
    tick();
    rst_ni = 1'b1;
    respond(2'b01, 2'b01);
    chk("t6_post_proto", 32'(a_proto), 1);
    chk("t6_post_count", 32'(a_count), 0);
    tick();
    chk("t6_post_nolog", 32'(a_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
